// File: rtl/sdp_ram_pkg.sv
// Shared types and default widths for the simple dual-port RAM arbiter.
// The optional post-reset RAM clear is enabled by the RAM_ARB_INIT_EN macro.
package sdp_ram_pkg;

  localparam int ADDR_W_DFLT = 10;
  localparam int DATA_W_DFLT = 32;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic {
    CLI_A = 1'b0,
    CLI_B = 1'b1
  } cli_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with a combinational grant and a registered
// last-grant pointer; a tie goes to the client that was not granted last.
module rr_arb2
  import sdp_ram_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_req_a,
  input  logic i_req_b,
  output logic o_gnt_a,
  output logic o_gnt_b
);

  cli_e last_q, last_d;

  assign o_gnt_a = i_en & i_req_a & (~i_req_b | (last_q == CLI_B));
  assign o_gnt_b = i_en & i_req_b & ~o_gnt_a;

  always_comb begin
    last_d = last_q;
    if (o_gnt_a)      last_d = CLI_A;
    else if (o_gnt_b) last_d = CLI_B;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its _d regardless of block evaluation order.
  always_ff @(posedge i_clk) begin
    if (i_rst) last_q <= CLI_B;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/sdp_ram_arbiter.sv
// Arbitrates two read clients and one write client onto a simple dual-port RAM.
// With RAM_ARB_INIT_EN defined the RAM is zero-filled after reset before RUN.
module sdp_ram_arbiter
  import sdp_ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int DATA_W = DATA_W_DFLT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rd_req_a,
  input  logic [ADDR_W-1:0] i_rd_addr_a,
  input  logic              i_rd_req_b,
  input  logic [ADDR_W-1:0] i_rd_addr_b,
  output logic              o_rd_gnt_a,
  output logic              o_rd_gnt_b,
  output logic              o_rsp_valid_a,
  output logic              o_rsp_valid_b,
  output logic [DATA_W-1:0] o_rsp_data,
  input  logic              i_wr_valid,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ready,
  output logic              o_ram_rd_en,
  output logic [ADDR_W-1:0] o_ram_rd_addr,
  input  logic [DATA_W-1:0] i_ram_dout,
  output logic              o_ram_wr_en,
  output logic [ADDR_W-1:0] o_ram_wr_addr,
  output logic [DATA_W-1:0] o_ram_wr_data,
  output logic              o_busy
);

  logic run;

`ifdef RAM_ARB_INIT_EN
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == INIT) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == '1) state_d = RUN;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= INIT;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign run = (state_q == RUN);
`else
  assign run = 1'b1;
`endif

  assign o_busy     = ~run;
  assign o_wr_ready = run;

  rr_arb2 u_arb (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (run),
    .i_req_a (i_rd_req_a),
    .i_req_b (i_rd_req_b),
    .o_gnt_a (o_rd_gnt_a),
    .o_gnt_b (o_rd_gnt_b)
  );

  assign o_ram_rd_en   = o_rd_gnt_a | o_rd_gnt_b;
  assign o_ram_rd_addr = o_rd_gnt_b ? i_rd_addr_b : i_rd_addr_a;

  logic              rsp_valid_a_q, rsp_valid_a_d;
  logic              rsp_valid_b_q, rsp_valid_b_d;
  logic              wr_en_q,   wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    rsp_valid_a_d = o_rd_gnt_a;
    rsp_valid_b_d = o_rd_gnt_b;
    wr_en_d       = i_wr_valid & run;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    if (i_wr_valid && run) begin
      wr_addr_d = i_wr_addr;
      wr_data_d = i_wr_data;
    end
`ifdef RAM_ARB_INIT_EN
    if (state_q == INIT) begin
      wr_en_d   = 1'b1;
      wr_addr_d = clr_cnt_q;
      wr_data_d = '0;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rsp_valid_a_q <= 1'b0;
      rsp_valid_b_q <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
    end else begin
      rsp_valid_a_q <= rsp_valid_a_d;
      rsp_valid_b_q <= rsp_valid_b_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
    end
  end

  assign o_rsp_valid_a = rsp_valid_a_q;
  assign o_rsp_valid_b = rsp_valid_b_q;
  // RAM output is only meaningful the cycle after a read; hold zero otherwise.
  assign o_rsp_data    = (rsp_valid_a_q | rsp_valid_b_q) ? i_ram_dout : '0;

  assign o_ram_wr_en   = wr_en_q;
  assign o_ram_wr_addr = wr_addr_q;
  assign o_ram_wr_data = wr_data_q;

endmodule

// File: doc/sdp_ram_arbiter.md
SDP_RAM_ARBITER -- requirements
Module: sdp_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, RAM address width.
REQ-002 SHALL have parameter DATA_W, default 32, RAM data width.
REQ-003 SHALL have port i_clk, input, 1, single clock; all logic on the rising edge.
REQ-004 SHALL have port i_rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have ports i_rd_req_a / i_rd_req_b, input, 1 each, read request from client A / B.
REQ-006 SHALL have ports i_rd_addr_a / i_rd_addr_b, input, ADDR_W each, read address of client A / B.
REQ-007 SHALL have ports o_rd_gnt_a / o_rd_gnt_b, output, 1 each, combinational grant; the request is accepted in this cycle.
REQ-008 SHALL have ports o_rsp_valid_a / o_rsp_valid_b, output, 1 each, read data valid for client A / B.
REQ-009 SHALL have port o_rsp_data, output, DATA_W, read data shared by both clients.
REQ-010 SHALL have ports i_wr_valid, input, 1; i_wr_addr, input, ADDR_W; i_wr_data, input, DATA_W: single write client.
REQ-011 SHALL have port o_wr_ready, output, 1, write accepted when i_wr_valid and o_wr_ready are both high.
REQ-012 SHALL have ports o_ram_rd_en (output, 1), o_ram_rd_addr (output, ADDR_W) and i_ram_dout (input, DATA_W) to drive the RAM read port; the RAM returns data 1 cycle after rd_en.
REQ-013 SHALL have ports o_ram_wr_en (output, 1), o_ram_wr_addr (output, ADDR_W) and o_ram_wr_data (output, DATA_W) to drive the RAM write port.
REQ-014 SHALL have port o_busy, output, 1, high while in the INIT state.

Function
REQ-015 The block SHALL implement the states INIT, RUN and the transitions between them as follows:
- Out of reset the state is INIT when RAM_ARB_INIT_EN is defined, otherwise RUN.
- INIT goes to RUN after the last clear write (REQ-024).
REQ-016 In RUN, at most one read grant SHALL be issued per cycle, using round-robin arbitration:
- If only one client requests, that client is granted.
- If both request, the client not granted most recently is granted.
- After reset the last-granted pointer is B, so A wins the first tie.
REQ-017 For a grant, o_ram_rd_en and o_ram_rd_addr SHALL be driven combinationally from the granted client's request and address in the same cycle.
REQ-018 The response SHALL appear exactly 1 cycle after the grant:
- o_rsp_valid_x is a registered copy of o_rd_gnt_x.
- o_rsp_data = i_ram_dout.
- There is no response backpressure.
REQ-019 o_rsp_valid_a and o_rsp_valid_b SHALL never be high in the same cycle.
REQ-020 Client writes SHALL be registered:
- On acceptance, o_ram_wr_en, o_ram_wr_addr and o_ram_wr_data are driven in the next cycle.
- o_wr_ready = 1 in RUN and 0 in INIT.
REQ-021 A read and a write to the same address in the same cycle SHALL be passed through unmodified, with no forwarding; the data returned is the RAM's own collision behaviour.
REQ-022 Address values SHALL be used modulo 2^ADDR_W with no range checking.
REQ-023 In INIT, o_rd_gnt_a, o_rd_gnt_b, o_ram_rd_en and o_wr_ready SHALL be 0; requests are held off, not dropped.

Reset
REQ-024 While i_rst = 1 at a clock edge, all of the following SHALL be cleared to 0:
- o_rsp_valid_a/b, o_rsp_data, o_ram_wr_en, o_ram_wr_addr, o_ram_wr_data
- the clear counter
- the last-granted pointer, set to B
The state is set per REQ-015, and o_busy = 1 iff the state is INIT.
REQ-025 A reset asserted mid-operation SHALL discard any in-flight response and any pending registered write.

Configuration
REQ-026 Macro RAM_ARB_INIT_EN SHALL control the post-reset clear:
- Defined: INIT writes 0 to addresses 0 .. 2^ADDR_W-1, one per cycle, via o_ram_wr_*. The state then goes to RUN, so o_busy is high for exactly 2^ADDR_W cycles after reset release.
- Undefined: there is no INIT state and no clear counter; o_busy is tied to 0 and the block starts in RUN.

Structure
REQ-027 Package sdp_ram_pkg SHALL hold the ADDR_W and DATA_W defaults, the state enum type (INIT, RUN) and the client-id enum type (CLI_A, CLI_B).
REQ-028 The round-robin grant logic SHALL be a sub-module rr_arb2 (2 requesters, registered last-grant pointer); everything else stays in sdp_ram_arbiter.

Verification
REQ-029 With RAM_ARB_INIT_EN defined, releasing reset SHALL give o_busy = 1 for 1024 cycles and wr_addr 0..1023 with data 0; a subsequent read of address 5 returns 0.
REQ-030 Writing 0xDEADBEEF to address 0x3FF, then A reading 0x3FF, SHALL give o_rsp_valid_a = 1 exactly 1 cycle after o_rd_gnt_a, with o_rsp_data = 0xDEADBEEF.
REQ-031 With A and B requesting continuously for 6 cycles, grants SHALL alternate A,B,A,B,A,B and responses alternate 1 cycle later.
REQ-032 With only B requesting for 3 cycles, B SHALL be granted in all 3 cycles; when A then joins in the next cycle, A is granted.
REQ-033 Asserting i_rst in the cycle after a grant SHALL keep o_rsp_valid_a/b at 0 on the following edge, with no stale response after reset release.
REQ-034 Client requests and i_wr_valid held during INIT SHALL be serviced on the first RUN cycle, with o_wr_ready = 0 throughout INIT.
